// File: rtl/keypad_calc_sequencer.sv
// Keypad-to-ALU sequencer: debounces decoder key codes, builds decimal operands and an operator,
// hands one request at a time to the ALU over valid/ready, and captures the result for display.
module keypad_calc_sequencer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       key_code,
  output logic [WIDTH-1:0] calc_a,
  output logic [WIDTH-1:0] calc_b,
  output logic [1:0]       calc_op,
  output logic             calc_valid,
  input  logic             calc_ready,
  input  logic [WIDTH-1:0] res_data,
  input  logic             res_valid,
  output logic [WIDTH-1:0] disp_value,
  output logic             busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [4:0] KEY_NONE = 5'h1F;

  typedef enum logic [2:0] {OPA, OPB, ISSUE, WAIT_RES, DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      prev_key_q, prev_key_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic [1:0]      op_q, op_d;
  logic            valid_q, valid_d;

  logic            key_ev;
  logic [4:0]      ev_code;
  logic            is_digit, is_op, is_eq, is_clr;
  logic [4:0]      op_full;
  logic [WIDTH-1:0] acc_a, acc_b, digit_val;

  // Append a decimal digit; a digit that would overflow WIDTH bits is dropped.
  function automatic logic [WIDTH-1:0] acc_digit(input logic [WIDTH-1:0] cur, input logic [3:0] d);
    logic [WIDTH+3:0] n;
    n = ({4'd0, cur} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, d};
    if (n > {4'd0, {WIDTH{1'b1}}}) return cur;
    else                           return n[WIDTH-1:0];
  endfunction

  always_comb begin
    prev_key_d = key_code;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    key_ev     = 1'b0;
    ev_code    = prev_key_q;
    if (key_code != prev_key_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_q == CNT_MAX) begin
      if (prev_key_q == KEY_NONE) begin
        armed_d = 1'b1;
      end else if (armed_q) begin
        key_ev  = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  always_comb begin
    is_digit  = key_ev && (ev_code <= 5'd9);
    is_op     = key_ev && (ev_code >= 5'hA) && (ev_code <= 5'hD);
    is_eq     = key_ev && (ev_code == 5'hE);
    is_clr    = key_ev && (ev_code == 5'hF);
    op_full   = ev_code - 5'hA;
    digit_val = {{(WIDTH-4){1'b0}}, ev_code[3:0]};
    acc_a     = acc_digit(a_q, ev_code[3:0]);
    acc_b     = acc_digit(b_q, ev_code[3:0]);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    disp_d  = disp_q;
    if (is_clr) begin
      state_d = OPA;
      a_d     = '0;
      b_d     = '0;
      op_d    = 2'd0;
      valid_d = 1'b0;
      disp_d  = '0;
    end else begin
      unique case (state_q)
        OPA: begin
          if (is_digit) begin
            a_d = acc_a;
          end else if (is_op) begin
            op_d    = op_full[1:0];
            b_d     = '0;
            state_d = OPB;
          end
        end
        OPB: begin
          if (is_digit) begin
            b_d = acc_b;
          end else if (is_op) begin
            op_d = op_full[1:0];
          end else if (is_eq) begin
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (valid_q && calc_ready) begin
            valid_d = 1'b0;
            state_d = WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_valid) begin
            disp_d  = res_data;
            state_d = DONE;
          end
        end
        DONE: begin
          if (is_digit) begin
            a_d     = digit_val;
            b_d     = '0;
            state_d = OPA;
          end else if (is_op) begin
            a_d     = disp_q;
            op_d    = op_full[1:0];
            b_d     = '0;
            state_d = OPB;
          end
        end
        default: state_d = OPA;
      endcase
      // Display tracks the operand being typed; in ISSUE/WAIT_RES/DONE it holds.
      if (state_d == OPA)      disp_d = a_d;
      else if (state_d == OPB) disp_d = b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OPA;
      prev_key_q <= KEY_NONE;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 2'd0;
      valid_q    <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      prev_key_q <= prev_key_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      valid_q    <= valid_d;
      disp_q     <= disp_d;
    end
  end

  assign calc_a     = a_q;
  assign calc_b     = b_q;
  assign calc_op    = op_q;
  assign calc_valid = valid_q;
  assign disp_value = disp_q;
  assign busy       = (state_q == ISSUE) || (state_q == WAIT_RES);

endmodule
